// File: rtl/bp_reg_master_pkg.sv
// -----------------------------------------------------------------------------
// bp_reg_master_pkg
//   Shared bytepipe definitions used by the register master and by the
//   register-memory responder on the other end of the bytepipe.
//
//   Contents:
//     BP_BYTE_W   - bytepipe byte width
//     CMD_ADDR_W  - register address width carried in a command byte
//     bpState_t   - register-master FSM state encoding
//     bpCmd_t     - command byte layout: write flag in bit 7, address in [6:0]
//     makeCmd()   - packs a write flag and an address into a command byte
// -----------------------------------------------------------------------------
package bp_reg_master_pkg;

    localparam int BP_BYTE_W  = 8;
    localparam int CMD_ADDR_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RWAIT = 3'd3,
        ST_RSP   = 3'd4
    } bpState_t;

    // Field order fixes the wire layout: first field is the MSB, so the write
    // flag lands on bit 7 and the address occupies bits [6:0].
    typedef struct packed {
        logic                  wr;
        logic [CMD_ADDR_W-1:0] addr;
    } bpCmd_t;

    function automatic logic [BP_BYTE_W-1:0] makeCmd(
        input logic                  wr,
        input logic [CMD_ADDR_W-1:0] addr
    );
        bpCmd_t cmd;
        cmd.wr   = wr;
        cmd.addr = addr;
        return cmd;
    endfunction

endpackage

// File: rtl/bp_reg_master.sv
// -----------------------------------------------------------------------------
// bp_reg_master
//   Turns register read/write requests into bytepipe traffic toward a
//   register-memory responder. A write sends {1,addr} then the data byte and
//   expects nothing back; a read sends {0,addr} and consumes exactly one
//   response byte, giving up after TIMEOUT_CYCLES cycles of silence.
//
//   Parameters:
//     TIMEOUT_CYCLES - cycles to wait for a read-response byte (>= 1)
//     ADDR_W         - register address width, must stay 7 (command byte)
//
//   Ports:
//     i_clk, i_rst          - clock, synchronous active-high reset
//     i_cg                  - clock-gate enable; 0 freezes all state
//     i_req_*/o_req_ready   - request channel (wr, addr, wdata)
//     o_rsp_*/i_rsp_ready   - completion channel (rdata, timeout flag)
//     o_bp_data/o_bp_valid/i_bp_ready - bytepipe out to the responder
//     i_bp_data/i_bp_valid/o_bp_ready - bytepipe in from the responder
//
//   All outputs are registered and updated together with the FSM.
// -----------------------------------------------------------------------------
module bp_reg_master
    import bp_reg_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int ADDR_W         = 7
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cg,

    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wr,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [7:0]        i_req_wdata,

    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [7:0]        o_rsp_rdata,
    output logic              o_rsp_timeout,

    output logic [7:0]        o_bp_data,
    output logic              o_bp_valid,
    input  logic              i_bp_ready,

    input  logic [7:0]        i_bp_data,
    input  logic              i_bp_valid,
    output logic              o_bp_ready
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Last count value before giving up, and the saturated value held after.
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    bpState_t          state;
    logic              reqWr;
    logic [7:0]        reqWdata;
    logic [CNT_W-1:0]  toCnt;

    // NOTE: every register here is assigned with <= so all of them update
    // from the same pre-edge values; blocking = would let later statements
    // see half-updated state and change behaviour with statement order.
    always_ff @(posedge i_clk) begin
        // Reset outranks the clock gate so a frozen block can still be cleared.
        if (i_rst) begin
            state         <= ST_IDLE;
            reqWr         <= 1'b0;
            reqWdata      <= '0;
            toCnt         <= '0;
            o_req_ready   <= 1'b1;
            o_rsp_valid   <= 1'b0;
            o_rsp_rdata   <= '0;
            o_rsp_timeout <= 1'b0;
            o_bp_valid    <= 1'b0;
            o_bp_data     <= '0;
            // Always ready: RWAIT consumes the byte, every other state flushes
            // stale or late bytes so they never back up the responder.
            o_bp_ready    <= 1'b1;
        end else if (i_cg) begin
            case (state)
                ST_IDLE: begin
                    // o_req_ready is 1 in this state, so valid alone accepts.
                    if (i_req_valid) begin
                        reqWr       <= i_req_wr;
                        reqWdata    <= i_req_wdata;
                        o_req_ready <= 1'b0;
                        o_bp_valid  <= 1'b1;
                        o_bp_data   <= makeCmd(i_req_wr, i_req_addr);
                        state       <= ST_CMD;
                    end
                end

                ST_CMD: begin
                    // Command byte is held until taken; never retracted.
                    if (i_bp_ready) begin
                        if (reqWr) begin
                            o_bp_data <= reqWdata;
                            state     <= ST_WDATA;
                        end else begin
                            o_bp_valid <= 1'b0;
                            o_bp_data  <= '0;
                            toCnt      <= '0;
                            state      <= ST_RWAIT;
                        end
                    end
                end

                ST_WDATA: begin
                    if (i_bp_ready) begin
                        o_bp_valid    <= 1'b0;
                        o_bp_data     <= '0;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_rdata   <= '0;
                        o_rsp_timeout <= 1'b0;
                        state         <= ST_RSP;
                    end
                end

                ST_RWAIT: begin
                    // A byte arriving on the final cycle still wins over the
                    // timeout.
                    if (i_bp_valid) begin
                        o_rsp_valid   <= 1'b1;
                        o_rsp_rdata   <= i_bp_data;
                        o_rsp_timeout <= 1'b0;
                        state         <= ST_RSP;
                    end else if (toCnt == CNT_LAST) begin
                        toCnt         <= CNT_MAX;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_rdata   <= '0;
                        o_rsp_timeout <= 1'b1;
                        state         <= ST_RSP;
                    end else if (toCnt != CNT_MAX) begin
                        toCnt <= toCnt + 1'b1;
                    end
                end

                ST_RSP: begin
                    // req_ready rises only in the following cycle, so a new
                    // request can never be taken on the completion edge.
                    if (i_rsp_ready) begin
                        o_rsp_valid   <= 1'b0;
                        o_rsp_rdata   <= '0;
                        o_rsp_timeout <= 1'b0;
                        o_req_ready   <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end

                default: begin
                    o_req_ready   <= 1'b1;
                    o_rsp_valid   <= 1'b0;
                    o_rsp_rdata   <= '0;
                    o_rsp_timeout <= 1'b0;
                    o_bp_valid    <= 1'b0;
                    o_bp_data     <= '0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bp_reg_master.sv
// -----------------------------------------------------------------------------
// tb_bp_reg_master
//   Self-checking bench for bp_reg_master (TIMEOUT_CYCLES = 15). A behavioural
//   register-memory responder lives in the bench; a plain array refMem holds
//   the register contents every read is expected to return.
//   All stimulus changes and all sampling happen on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bp_reg_master;

    localparam int TIMEOUT = 15;
    localparam logic [20:0] IDLE_OUTS = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};

    logic       i_clk, i_rst, i_cg;
    logic       i_req_valid, o_req_ready, i_req_wr;
    logic [6:0] i_req_addr;
    logic [7:0] i_req_wdata;
    logic       o_rsp_valid, i_rsp_ready, o_rsp_timeout;
    logic [7:0] o_rsp_rdata;
    logic [7:0] o_bp_data;
    logic       o_bp_valid, i_bp_ready;
    logic [7:0] i_bp_data;
    logic       i_bp_valid, o_bp_ready;

    bp_reg_master #(.TIMEOUT_CYCLES(TIMEOUT), .ADDR_W(7)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wr(i_req_wr),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_timeout(o_rsp_timeout),
        .o_bp_data(o_bp_data), .o_bp_valid(o_bp_valid), .i_bp_ready(i_bp_ready),
        .i_bp_data(i_bp_data), .i_bp_valid(i_bp_valid), .o_bp_ready(o_bp_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int acceptCnt = 0, rspCnt = 0, cmdCnt = 0;
    int lastAcceptCycle = 0, lastRspCycle = 0, lastCmdCycle = 0;

    logic [7:0] sentQ[$];
    logic [7:0] respMem [128];
    logic [7:0] refMem  [128];

    // Responder knobs and parser state.
    bit         respSilent  = 1'b0;
    int         bpReadyMode = 0;   // 0 always ready, 1 random, 2 never
    int         maxDelay    = 0;
    bit         rspRandom   = 1'b0;
    bit         expectData  = 1'b0;
    logic [6:0] wrAddr      = '0;
    bit         rdPend      = 1'b0;
    int         rdDelay     = 0;
    logic [7:0] rdData      = '0;

    function automatic logic [20:0] outVec();
        return {o_req_ready, o_rsp_valid, o_rsp_timeout, o_bp_valid, o_bp_ready,
                o_rsp_rdata, o_bp_data};
    endfunction

    // One clock: note which handshakes fire at the coming edge, step to the
    // next falling edge, check hold rules, run the responder.
    task automatic tick();
        bit         act, fireBp, fireReq, fireRsp, holdBp, holdRsp, rstNow;
        logic [7:0] prevBpData, prevRdata;
        logic       prevTo;
        act        = i_cg && !i_rst;
        fireBp     = act && o_bp_valid && i_bp_ready;
        fireReq    = act && i_req_valid && o_req_ready;
        fireRsp    = act && o_rsp_valid && i_rsp_ready;
        holdBp     = !i_rst && o_bp_valid && !i_bp_ready;
        holdRsp    = !i_rst && o_rsp_valid && !i_rsp_ready;
        prevBpData = o_bp_data;
        prevRdata  = o_rsp_rdata;
        prevTo     = o_rsp_timeout;
        rstNow     = i_rst;
        @(posedge i_clk);
        @(negedge i_clk);
        cycle++;
        if (fireReq) begin acceptCnt++; lastAcceptCycle = cycle; end
        if (fireRsp) begin rspCnt++; lastRspCycle = cycle; end
        if (holdBp) begin
            tests++;
            if (o_bp_valid !== 1'b1 || o_bp_data !== prevBpData) begin
                fails++;
                $display("FAIL bp_hold @%0d: valid=%b data=%h, need valid=1 data=%h",
                         cycle, o_bp_valid, o_bp_data, prevBpData);
            end
        end
        if (holdRsp) begin
            tests++;
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== prevRdata || o_rsp_timeout !== prevTo) begin
                fails++;
                $display("FAIL rsp_hold @%0d: valid=%b rdata=%h to=%b, need 1 %h %b",
                         cycle, o_rsp_valid, o_rsp_rdata, o_rsp_timeout, prevRdata, prevTo);
            end
        end
        if (rstNow) begin
            expectData = 1'b0;
            rdPend     = 1'b0;
        end else if (fireBp) begin
            sentQ.push_back(prevBpData);
            if (expectData) begin
                respMem[wrAddr] = prevBpData;
                expectData      = 1'b0;
            end else begin
                cmdCnt++;
                lastCmdCycle = cycle;
                if (prevBpData[7]) begin
                    expectData = 1'b1;
                    wrAddr     = prevBpData[6:0];
                end else if (!respSilent) begin
                    rdPend  = 1'b1;
                    rdDelay = $urandom_range(maxDelay, 0);
                    rdData  = respMem[prevBpData[6:0]];
                end
            end
        end
        i_bp_valid = 1'b0;
        if (rdPend) begin
            if (rdDelay == 0) begin
                i_bp_valid = 1'b1;
                i_bp_data  = rdData;
                rdPend     = 1'b0;
            end else begin
                rdDelay--;
            end
        end
        case (bpReadyMode)
            0:       i_bp_ready = 1'b1;
            1:       i_bp_ready = ($urandom_range(3, 0) != 0);
            default: i_bp_ready = 1'b0;
        endcase
        if (rspRandom) i_rsp_ready = ($urandom_range(1, 0) == 1);
    endtask

    // Runs one complete request; ok=0 means a wait bound expired.
    task automatic doReq(input logic wr, input logic [6:0] addr, input logic [7:0] wdata,
                         output logic [7:0] rdata, output logic to,
                         output int rspLat, output int cmdLat, output bit ok);
        int n;
        int accCycle;
        ok = 1'b1; rdata = 'x; to = 1'bx; rspLat = -1; cmdLat = -1;
        sentQ.delete();
        i_req_valid = 1'b1; i_req_wr = wr; i_req_addr = addr; i_req_wdata = wdata;
        n = acceptCnt;
        for (int k = 0; k < 50 && acceptCnt == n; k++) tick();
        i_req_valid = 1'b0;
        if (acceptCnt == n) begin ok = 1'b0; return; end
        accCycle = cycle;
        for (int k = 0; k < 100 && o_rsp_valid !== 1'b1; k++) tick();
        if (o_rsp_valid !== 1'b1) begin ok = 1'b0; return; end
        rspLat = cycle - accCycle + 1;
        cmdLat = cycle - lastCmdCycle;
        rdata  = o_rsp_rdata;
        to     = o_rsp_timeout;
        n = rspCnt;
        for (int k = 0; k < 100 && rspCnt == n; k++) tick();
        if (rspCnt == n) ok = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_cg = 1'b0;
        tick(); tick();
        tests++;
        if (outVec() !== IDLE_OUTS) begin
            fails++; $display("FAIL reset_cg0: outs=%h want %h", outVec(), IDLE_OUTS);
        end
        i_cg = 1'b1; tick();
        tests++;
        if (outVec() !== IDLE_OUTS) begin
            fails++; $display("FAIL reset_cg1: outs=%h want %h", outVec(), IDLE_OUTS);
        end
        i_rst = 1'b0; tick(); tick();
        tests++;
        if (outVec() !== IDLE_OUTS) begin
            fails++; $display("FAIL idle_after_reset: outs=%h want %h", outVec(), IDLE_OUTS);
        end
    endtask

    task automatic test_write_latency();
        int lat;
        int n;
        bpReadyMode = 0; i_rsp_ready = 1'b0; sentQ.delete();
        n = acceptCnt;
        i_req_valid = 1'b1; i_req_wr = 1'b1; i_req_addr = 7'h01; i_req_wdata = 8'hA5;
        tick();
        i_req_valid = 1'b0;
        tests++;
        if (acceptCnt != n + 1 || o_req_ready !== 1'b0) begin
            fails++; $display("FAIL wr_accept: accepts=%0d ready=%b want %0d 0", acceptCnt - n, o_req_ready, 1);
        end
        lat = 1;
        for (int k = 0; k < 20 && o_rsp_valid !== 1'b1; k++) begin tick(); lat++; end
        tests++;
        if (lat != 3) begin fails++; $display("FAIL wr_latency: got %0d want 3", lat); end
        tests++;
        if (sentQ.size() != 2 || sentQ[0] !== 8'h81 || sentQ[1] !== 8'hA5) begin
            fails++; $display("FAIL wr_bytes: n=%0d first=%h want 2 bytes 81 a5", sentQ.size(), sentQ.size() > 0 ? sentQ[0] : 8'hxx);
        end
        tests++;
        if (o_rsp_rdata !== 8'h00 || o_rsp_timeout !== 1'b0) begin
            fails++; $display("FAIL wr_rsp: rdata=%h to=%b want 00 0", o_rsp_rdata, o_rsp_timeout);
        end
        tick(); tick();
        tests++;
        if (o_rsp_valid !== 1'b1 || o_req_ready !== 1'b0) begin
            fails++; $display("FAIL wr_rsp_wait: valid=%b ready=%b want 1 0", o_rsp_valid, o_req_ready);
        end
        i_rsp_ready = 1'b1; tick(); i_rsp_ready = 1'b0;
        tests++;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            fails++; $display("FAIL wr_rsp_done: valid=%b ready=%b want 0 1", o_rsp_valid, o_req_ready);
        end
        refMem[1] = 8'hA5;
    endtask

    task automatic test_write_read();
        logic [7:0] rd; logic to; int rl, cl; bit ok;
        maxDelay = 3; i_rsp_ready = 1'b1;
        doReq(1'b0, 7'h01, 8'h00, rd, to, rl, cl, ok);
        tests++;
        if (!ok || sentQ.size() != 1 || sentQ[0] !== 8'h01) begin
            fails++; $display("FAIL rd_bytes: ok=%b n=%0d want ok=1 one byte 01", ok, sentQ.size());
        end
        tests++;
        if (rd !== refMem[1] || to !== 1'b0) begin
            fails++; $display("FAIL rd_data: rdata=%h to=%b want %h 0", rd, to, refMem[1]);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] rd; logic to; int rl, cl; bit ok;
        respSilent = 1'b1; i_rsp_ready = 1'b1;
        doReq(1'b0, 7'h7F, 8'h00, rd, to, rl, cl, ok);
        tests++;
        if (!ok || cl != TIMEOUT) begin
            fails++; $display("FAIL to_cycles: ok=%b rwait=%0d want ok=1 %0d", ok, cl, TIMEOUT);
        end
        tests++;
        if (rd !== 8'h00 || to !== 1'b1) begin
            fails++; $display("FAIL to_rsp: rdata=%h to=%b want 00 1", rd, to);
        end
        // Late byte shows up in IDLE and must vanish.
        i_bp_valid = 1'b1; i_bp_data = 8'h5A;
        tick(); tick();
        tests++;
        if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
            fails++; $display("FAIL late_byte_idle: ready=%b rsp=%b want 1 0", o_req_ready, o_rsp_valid);
        end
        respSilent = 1'b0; maxDelay = 2;
        doReq(1'b0, 7'h7F, 8'h00, rd, to, rl, cl, ok);
        tests++;
        if (!ok || rd !== refMem[7'h7F] || to !== 1'b0) begin
            fails++; $display("FAIL after_late_byte: ok=%b rdata=%h to=%b want 1 %h 0", ok, rd, to, refMem[7'h7F]);
        end
    endtask

    task automatic test_back_to_back();
        int n; int r0; logic [7:0] d;
        bpReadyMode = 0; maxDelay = 0; i_rsp_ready = 1'b1;
        d = 8'($urandom);
        n = acceptCnt;
        i_req_valid = 1'b1; i_req_wr = 1'b1; i_req_addr = 7'h05; i_req_wdata = d;
        for (int k = 0; k < 10 && acceptCnt == n; k++) tick();
        i_req_wr = 1'b0;
        n = acceptCnt; r0 = rspCnt;
        for (int k = 0; k < 40 && acceptCnt == n; k++) tick();
        i_req_valid = 1'b0;
        refMem[5] = d;
        tests++;
        if (rspCnt != r0 + 1 || lastAcceptCycle - lastRspCycle != 1) begin
            fails++; $display("FAIL b2b_gap: rsps=%0d gap=%0d want 1 1", rspCnt - r0, lastAcceptCycle - lastRspCycle);
        end
        for (int k = 0; k < 40 && o_rsp_valid !== 1'b1; k++) tick();
        tests++;
        if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== refMem[5]) begin
            fails++; $display("FAIL b2b_read: valid=%b rdata=%h want 1 %h", o_rsp_valid, o_rsp_rdata, refMem[5]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n; bit sawRsp;
        logic [7:0] rd; logic to; int rl, cl; bit ok;
        bpReadyMode = 0; i_rsp_ready = 1'b1;
        n = acceptCnt;
        i_req_valid = 1'b1; i_req_wr = 1'b1; i_req_addr = 7'h10; i_req_wdata = 8'h33;
        for (int k = 0; k < 10 && acceptCnt == n; k++) tick();
        i_req_valid = 1'b0;
        n = cmdCnt;
        for (int k = 0; k < 10 && cmdCnt == n; k++) tick();
        bpReadyMode = 2; i_bp_ready = 1'b0;
        tests++;
        if (o_bp_valid !== 1'b1 || o_bp_data !== 8'h33) begin
            fails++; $display("FAIL rst_mid_wdata: valid=%b data=%h want 1 33", o_bp_valid, o_bp_data);
        end
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        tests++;
        if (outVec() !== IDLE_OUTS) begin
            fails++; $display("FAIL rst_mid_idle: outs=%h want %h", outVec(), IDLE_OUTS);
        end
        bpReadyMode = 0; sentQ.delete(); sawRsp = 1'b0;
        for (int k = 0; k < 6; k++) begin tick(); if (o_rsp_valid !== 1'b0) sawRsp = 1'b1; end
        tests++;
        if (sawRsp || sentQ.size() != 0) begin
            fails++; $display("FAIL rst_mid_quiet: rsp=%b bytes=%0d want 0 0", sawRsp, sentQ.size());
        end
        maxDelay = 4;
        doReq(1'b0, 7'h10, 8'h00, rd, to, rl, cl, ok);
        tests++;
        if (!ok || rd !== refMem[7'h10] || to !== 1'b0) begin
            fails++; $display("FAIL rst_mid_reg: ok=%b rdata=%h want 1 %h", ok, rd, refMem[7'h10]);
        end
    endtask

    task automatic test_clock_gate();
        int n; int c;
        respSilent = 1'b1; bpReadyMode = 0; i_rsp_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            n = acceptCnt;
            i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = 7'h22;
            for (int k = 0; k < 10 && acceptCnt == n; k++) tick();
            i_req_valid = 1'b0;
            n = cmdCnt;
            for (int k = 0; k < 10 && cmdCnt == n; k++) tick();
            c = cycle;
            tick(); tick(); tick();
            i_cg = 1'b0;
            for (int k = 0; k < 10; k++) begin
                tick();
                tests++;
                if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b0 || o_bp_valid !== 1'b0) begin
                    fails++; $display("FAIL cg_frozen: rsp=%b req_ready=%b bp_valid=%b want 0 0 0", o_rsp_valid, o_req_ready, o_bp_valid);
                end
            end
            i_cg = 1'b1;
            if (pass == 0) begin
                for (int k = 0; k < 40 && o_rsp_valid !== 1'b1; k++) tick();
                tests++;
                if (cycle - c != TIMEOUT + 10 || o_rsp_timeout !== 1'b1 || o_rsp_rdata !== 8'h00) begin
                    fails++; $display("FAIL cg_timeout: cycles=%0d to=%b rdata=%h want %0d 1 00", cycle - c, o_rsp_timeout, o_rsp_rdata, TIMEOUT + 10);
                end
            end else begin
                i_bp_valid = 1'b1; i_bp_data = 8'h6C;
                tick();
                tests++;
                if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 8'h6C || o_rsp_timeout !== 1'b0) begin
                    fails++; $display("FAIL cg_resume: valid=%b rdata=%h to=%b want 1 6c 0", o_rsp_valid, o_rsp_rdata, o_rsp_timeout);
                end
            end
            tick();
        end
        respSilent = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] rd, d; logic to, wr; logic [6:0] a; int rl, cl; bit ok;
        bpReadyMode = 1; rspRandom = 1'b1; maxDelay = 8; respSilent = 1'b0;
        for (int i = 0; i < 200; i++) begin
            wr = $urandom_range(1, 0);
            a  = ($urandom_range(3, 0) == 0) ? 7'($urandom) : 7'($urandom_range(15, 0));
            d  = 8'($urandom);
            doReq(wr, a, d, rd, to, rl, cl, ok);
            tests++;
            if (!ok || sentQ.size() != (wr ? 2 : 1) || sentQ[0] !== {wr, a} || (wr && sentQ[1] !== d)) begin
                fails++; $display("FAIL rand_bytes #%0d: ok=%b n=%0d cmd=%h want %h", i, ok, sentQ.size(), sentQ.size() > 0 ? sentQ[0] : 8'hxx, {wr, a});
            end
            tests++;
            if (rd !== (wr ? 8'h00 : refMem[a]) || to !== 1'b0) begin
                fails++; $display("FAIL rand_rsp #%0d: wr=%b addr=%h rdata=%h to=%b want %h 0", i, wr, a, rd, to, wr ? 8'h00 : refMem[a]);
            end
            if (wr) refMem[a] = d;
        end
        rspRandom = 1'b0; bpReadyMode = 0; i_rsp_ready = 1'b1;
    endtask

    initial begin
        i_rst = 1'b1; i_cg = 1'b0;
        i_req_valid = 1'b0; i_req_wr = 1'b0; i_req_addr = '0; i_req_wdata = '0;
        i_rsp_ready = 1'b0; i_bp_ready = 1'b1; i_bp_valid = 1'b0; i_bp_data = '0;
        for (int i = 0; i < 128; i++) begin
            respMem[i] = 8'((i * 37) ^ 8'h5C);
            refMem[i]  = 8'((i * 37) ^ 8'h5C);
        end
        test_reset();
        test_write_latency();
        test_write_read();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_clock_gate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bp_reg_master.md
BP_REG_MASTER -- requirements
Module: bp_reg_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023; max cycles to wait for a read-response byte before aborting.
REQ-002 Parameter ADDR_W, default 7; register address width, fixed at 7 to match the bytepipe command byte.
REQ-003 i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_cg  input  1  clock-gate enable; when 0, all state holds.
REQ-006 i_req_valid/o_req_ready  input/output  1/1  request handshake; transfer when both high.
REQ-007 i_req_wr  input  1  1=write, 0=read.
REQ-008 i_req_addr  input  7  register address.
REQ-009 i_req_wdata  input  8  write data; ignored for reads.
REQ-010 o_rsp_valid/i_rsp_ready  output/input  1/1  completion handshake.
REQ-011 o_rsp_rdata  output  8  read data; 0 for writes and timeouts.
REQ-012 o_rsp_timeout  output  1  read aborted by timeout.
REQ-013 o_bp_data/o_bp_valid/i_bp_ready  output/output/input  8/1/1  bytepipe toward the register-memory responder.
REQ-014 i_bp_data/i_bp_valid/o_bp_ready  input/input/output  8/1/1  bytepipe from the responder.

Function
REQ-015 Command byte SHALL be {wr, addr[6:0]}; a write SHALL send the command byte then the data byte and expect no response; a read SHALL send the command byte then consume exactly one response byte.
REQ-016 FSM states: IDLE, CMD, WDATA, RWAIT, RSP.
REQ-017 IDLE: o_req_ready=1; on accept, latch wr/addr/wdata -> CMD next cycle.
REQ-018 CMD: o_bp_valid=1, o_bp_data={wr,addr}; on i_bp_ready: wr -> WDATA, rd -> RWAIT with timeout counter cleared.
REQ-019 WDATA: o_bp_valid=1, o_bp_data=wdata; on i_bp_ready -> RSP with rdata=0, timeout=0.
REQ-020 RWAIT: o_bp_ready=1; on i_bp_valid latch i_bp_data into rdata -> RSP, timeout=0; counter increments each cycle, reaching TIMEOUT_CYCLES -> RSP with rdata=0, timeout=1.
REQ-021 RSP: o_rsp_valid=1 with outputs stable; on i_rsp_ready -> IDLE; request accepted again at earliest the following cycle (no same-cycle back-to-back).
REQ-022 o_bp_valid SHALL stay high and o_bp_data stable until accepted (no retraction).
REQ-023 Outside RWAIT, o_bp_ready=1 and incoming bytes SHALL be discarded (stale/late bytes flushed), counted in no state.
REQ-024 Minimum latency: write = 3 cycles accept-to-o_rsp_valid with i_bp_ready held high; read = 2 cycles plus responder delay.
REQ-025 Timeout counter width $clog2(TIMEOUT_CYCLES+1), saturating; no wrap.
REQ-026 i_cg=0 SHALL freeze FSM, counter and latched registers; outputs reflect frozen state.

Reset
REQ-027 On i_rst: state=IDLE, counter=0, o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_timeout=0, o_bp_valid=0, o_bp_data=0, o_bp_ready=1.
REQ-028 Reset mid-transaction SHALL abandon it without emitting o_rsp_valid; partially sent command SHALL not be resent.
REQ-029 Reset SHALL take effect regardless of i_cg.

Structure
REQ-030 FSM state encoding and the command-byte field positions (write bit 7, address [6:0]) SHALL live in a shared bytepipe package used also by the register-memory responder.
REQ-031 Single flat module; no sub-modules beyond standard dff macros.

Verification
REQ-032 Write addr 0x01 data 0xA5, responder always ready -> bytes 0x81, 0xA5 out; o_rsp_valid 3 cycles after accept, rdata=0, timeout=0.
REQ-033 Write then read addr 0x01 against register-memory responder over bytepipe -> byte 0x01 out, rdata=0xA5, timeout=0.
REQ-034 Read addr 0x7F, responder silent, TIMEOUT_CYCLES=15 -> rsp after 15 RWAIT cycles, rdata=0, timeout=1; late byte later discarded in IDLE.
REQ-035 Random i_bp_ready/i_rsp_ready backpressure over 200 mixed requests -> o_bp_data stable while valid&&!ready; scoreboard matches all reads.
REQ-036 Assert i_rst in WDATA after command byte accepted -> next cycle IDLE, o_bp_valid=0, no o_rsp_valid.
REQ-037 i_cg=0 for 10 cycles in RWAIT -> counter unchanged, no state change; resumes correctly on i_cg=1.
